// File: rtl/patch_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : patch_arbiter_if
//  Purpose  : Bundles the request, acknowledge and output-stream signals of
//             the patch arbiter. The slave modport is the arbiter side; the
//             master modport is the requester / datapath side.
//  Revision : 1.0  initial release
// ============================================================================
interface patch_arbiter_if #(
  parameter int FP_SIZE = 32,
  parameter int N_PATCH = 600000,
  parameter int N_REQ   = 4
);
  localparam int c_pw = $clog2(N_PATCH);
  localparam int c_sw = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]         req;
  logic [N_REQ*c_pw-1:0]    req_patch;
  logic [N_REQ*FP_SIZE-1:0] req_x;
  logic [N_REQ-1:0]         ack;
  logic                     out_valid;
  logic                     out_ready;
  logic [c_pw-1:0]          patch_num;
  logic [FP_SIZE-1:0]       x;
  logic [c_sw-1:0]          out_src;
  logic [31:0]              xfer_cnt;
  logic [15:0]              err_cnt;
  logic                     err;

  modport slave (
    input  req, req_patch, req_x, out_ready,
    output ack, out_valid, patch_num, x, out_src, xfer_cnt, err_cnt, err
  );

  modport master (
    output req, req_patch, req_x, out_ready,
    input  ack, out_valid, patch_num, x, out_src, xfer_cnt, err_cnt, err
  );
endinterface
`default_nettype wire

// File: rtl/patch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : patch_arbiter
//  Purpose  : Round-robin arbiter feeding a single-slot output register.
//             Requests with an out-of-range patch number are acknowledged
//             and dropped, and counted in a saturating error counter.
//  Revision : 1.0  initial release
// ============================================================================
module patch_arbiter #(
  parameter int DELAY   = 1,
  parameter int FP_SIZE = 32,
  parameter int N_PATCH = 600000,
  parameter int N_REQ   = 4
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  patch_arbiter_if.slave   bus
);
  localparam int c_pw = $clog2(N_PATCH);
  localparam int c_sw = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // DELAY is kept so existing instantiations elaborate unchanged; state
  // updates themselves are zero-delay. Out-of-range setups stop elaboration.
  if (N_REQ < 2 || N_REQ > 8 || DELAY < 0) begin : g_param_check
    $error("patch_arbiter: N_REQ must be 2..8 and DELAY non-negative");
  end

  logic [c_sw-1:0]    r_ptr;
  logic               r_out_valid;
  logic [c_pw-1:0]    r_patch_num;
  logic [FP_SIZE-1:0] r_x;
  logic [c_sw-1:0]    r_out_src;
  logic [31:0]        r_xfer_cnt;
  logic [15:0]        r_err_cnt;
  logic               r_err;

  logic               w_open;
  logic               w_found;
  logic [c_sw-1:0]    w_cand;
  logic [c_sw-1:0]    w_gidx;
  logic               w_grant;
  logic [c_pw-1:0]    w_sel_patch;
  logic [FP_SIZE-1:0] w_sel_x;
  logic               w_in_range;
  logic               w_xfer;
  logic [N_REQ-1:0]   w_ack;

  // Slot can take new data when empty or being drained this cycle.
  assign w_open  = !r_out_valid || bus.out_ready;
  assign w_xfer  = r_out_valid && bus.out_ready;
  assign w_grant = w_open && w_found && !RESET;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = c_sw'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_sel_patch = bus.req_patch[int'(w_gidx)*c_pw +: c_pw];
  assign w_sel_x     = bus.req_x[int'(w_gidx)*FP_SIZE +: FP_SIZE];
  assign w_in_range  = 32'(w_sel_patch) < 32'(N_PATCH);

  // One-hot acknowledge for the winning requester in the grant cycle.
  always_comb begin
    w_ack = '0;
    if (w_grant) w_ack[w_gidx] = 1'b1;
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr       <= c_sw'(N_REQ - 1);
      r_out_valid <= 1'b0;
      r_patch_num <= '0;
      r_x         <= '0;
      r_out_src   <= '0;
    end else begin
      if (w_grant) r_ptr <= w_gidx;
      if (w_grant && w_in_range) begin
        r_out_valid <= 1'b1;
        r_patch_num <= w_sel_patch;
        r_x         <= w_sel_x;
        r_out_src   <= w_gidx;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Transfer counter (wrapping) and drop counter (saturating) with sticky flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_xfer_cnt <= '0;
      r_err_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_xfer) r_xfer_cnt <= r_xfer_cnt + 32'd1;
      if (w_grant && !w_in_range) begin
        r_err <= 1'b1;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign bus.ack       = w_ack;
  assign bus.out_valid = r_out_valid;
  assign bus.patch_num = r_patch_num;
  assign bus.x         = r_x;
  assign bus.out_src   = r_out_src;
  assign bus.xfer_cnt  = r_xfer_cnt;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.err       = r_err;
endmodule
`default_nettype wire
